// File: rtl/bitcoin_job_dispatcher.sv
// Drives 20-word mining jobs out of an AXI-Stream master, collects 8-word hash
// results on the slave port and sweeps the nonce range until a hash <= target.
module bitcoin_job_dispatcher #(
   parameter int C_M_AXIS_TDATA_WIDTH = 32,
   parameter int C_S_AXIS_TDATA_WIDTH = 32,
   parameter int JOB_WORDS            = 20,
   parameter int HASH_WORDS           = 8
) (
   input  logic                                axis_aclk,
   input  logic                                axis_aresetn,
   input  logic                                start,
   input  logic                                stop,
   input  logic [(JOB_WORDS-1)*32-1:0]         header,
   input  logic [31:0]                         nonce_start,
   input  logic [31:0]                         nonce_count,
   input  logic [HASH_WORDS*32-1:0]            target,
   output logic                                busy,
   output logic                                done,
   output logic                                found,
   output logic                                proto_err,
   output logic [31:0]                         found_nonce,
   output logic [HASH_WORDS*32-1:0]            found_hash,
   output logic [31:0]                         tries,
   output logic                                m00_axis_tvalid,
   output logic [C_M_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
   output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
   output logic                                m00_axis_tlast,
   input  logic                                m00_axis_tready,
   input  logic                                s00_axis_tvalid,
   input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
   input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
   input  logic                                s00_axis_tlast,
   output logic                                s00_axis_tready
);

   localparam int WPTR_W = $clog2(JOB_WORDS);
   localparam int RPTR_W = $clog2(HASH_WORDS);
   localparam logic [WPTR_W-1:0] LAST_WORD = WPTR_W'(JOB_WORDS - 1);
   localparam logic [RPTR_W-1:0] LAST_HASH = RPTR_W'(HASH_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_RECV,
      S_CHECK,
      S_FINISH
   } state_t;

   state_t                  r_state;
   logic [WPTR_W-1:0]       r_wptr;
   logic [RPTR_W-1:0]       r_rptr;
   logic [31:0]             r_cur_nonce;
   logic [31:0]             r_remaining;
   logic [31:0]             r_header [0:JOB_WORDS-2];
   logic [31:0]             r_hash_w [0:HASH_WORDS-1];
   logic [HASH_WORDS*32-1:0] r_target;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_found;
   logic                    r_proto_err;
   logic [31:0]             r_found_nonce;
   logic [HASH_WORDS*32-1:0] r_found_hash;
   logic [31:0]             r_tries;
   logic                    r_tvalid;
   logic                    r_tready;

   logic                    w_m_hs;
   logic                    w_s_hs;
   logic [31:0]             w_word;
   logic [HASH_WORDS*32-1:0] w_hash;
   logic                    w_hit;
   logic                    w_unused_tstrb;

   assign w_m_hs         = r_tvalid && m00_axis_tready;
   assign w_s_hs         = r_tready && s00_axis_tvalid;
   assign w_word         = (r_wptr == LAST_WORD) ? r_cur_nonce : r_header[r_wptr];
   assign w_hit          = (w_hash <= r_target);
   assign w_unused_tstrb = ^s00_axis_tstrb;

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      w_hash = '0;
      for (int k = 0; k < HASH_WORDS; k++) begin
         w_hash[k*32 +: 32] = r_hash_w[k];
      end
   end

   // NOTE: job/hash storage is qualified by the FSM before use, so it carries no reset.
   always_ff @(posedge axis_aclk) begin
      if (r_state == S_IDLE && start) begin
         for (int j = 0; j < JOB_WORDS - 1; j++) begin
            r_header[j] <= header[j*32 +: 32];
         end
         r_target <= target;
      end
      if (w_s_hs) begin
         r_hash_w[r_rptr] <= s00_axis_tdata;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge axis_aclk) begin
      if (!axis_aresetn) begin
         r_state       <= S_IDLE;
         r_wptr        <= '0;
         r_rptr        <= '0;
         r_cur_nonce   <= '0;
         r_remaining   <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_found       <= 1'b0;
         r_proto_err   <= 1'b0;
         r_found_nonce <= '0;
         r_found_hash  <= '0;
         r_tries       <= '0;
         r_tvalid      <= 1'b0;
         r_tready      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_cur_nonce   <= nonce_start;
                  r_remaining   <= nonce_count;
                  r_found       <= 1'b0;
                  r_proto_err   <= 1'b0;
                  r_tries       <= '0;
                  r_found_nonce <= '0;
                  r_found_hash  <= '0;
                  r_wptr        <= '0;
                  r_rptr        <= '0;
                  r_busy        <= 1'b1;
                  if (nonce_count == 32'd0) begin
                     r_done  <= 1'b1;
                     r_state <= S_FINISH;
                  end else begin
                     r_tvalid <= 1'b1;
                     r_state  <= S_SEND;
                  end
               end
            end
            S_SEND: begin
               if (w_m_hs) begin
                  if (r_wptr == LAST_WORD) begin
                     r_wptr   <= '0;
                     r_tvalid <= 1'b0;
                     r_tready <= 1'b1;
                     r_state  <= S_RECV;
                  end else begin
                     r_wptr <= r_wptr + 1'b1;
                  end
               end
            end
            S_RECV: begin
               if (w_s_hs) begin
                  if (r_rptr == LAST_HASH) begin
                     // A missing tlast is flagged, but the full hash is still checked.
                     if (!s00_axis_tlast) r_proto_err <= 1'b1;
                     r_tries  <= r_tries + 32'd1;
                     r_rptr   <= '0;
                     r_tready <= 1'b0;
                     r_state  <= S_CHECK;
                  end else if (s00_axis_tlast) begin
                     r_proto_err <= 1'b1;
                     r_rptr      <= '0;
                     r_tready    <= 1'b0;
                     r_done      <= 1'b1;
                     r_state     <= S_FINISH;
                  end else begin
                     r_rptr <= r_rptr + 1'b1;
                  end
               end
            end
            S_CHECK: begin
               r_found_hash  <= w_hash;
               r_found_nonce <= r_cur_nonce;
               if (w_hit) begin
                  r_found <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= S_FINISH;
               end else if (r_remaining == 32'd1 || stop) begin
                  r_done  <= 1'b1;
                  r_state <= S_FINISH;
               end else begin
                  r_cur_nonce <= r_cur_nonce + 32'd1;
                  r_remaining <= r_remaining - 32'd1;
                  r_tvalid    <= 1'b1;
                  r_state     <= S_SEND;
               end
            end
            S_FINISH: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy            = r_busy;
   assign done            = r_done;
   assign found           = r_found;
   assign proto_err       = r_proto_err;
   assign found_nonce     = r_found_nonce;
   assign found_hash      = r_found_hash;
   assign tries           = r_tries;
   assign m00_axis_tvalid = r_tvalid;
   assign m00_axis_tdata  = r_tvalid ? C_M_AXIS_TDATA_WIDTH'(w_word) : '0;
   assign m00_axis_tstrb  = {(C_M_AXIS_TDATA_WIDTH/8){r_tvalid}};
   assign m00_axis_tlast  = r_tvalid && (r_wptr == LAST_WORD);
   assign s00_axis_tready = r_tready;

endmodule

// File: tb/tb_bitcoin_job_dispatcher.sv
// Directed bench for bitcoin_job_dispatcher: scoreboard of sent words, scripted
// hash responder, optional random backpressure and gapped results.
module tb_bitcoin_job_dispatcher;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } beat_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         stop = 1'b0;
   logic [607:0] header = '0;
   logic [31:0]  nonce_start = '0;
   logic [31:0]  nonce_count = '0;
   logic [255:0] target = '0;
   logic         busy, done, found, proto_err;
   logic [31:0]  found_nonce, tries;
   logic [255:0] found_hash;
   logic         m_tvalid, m_tlast;
   logic [31:0]  m_tdata;
   logic [3:0]   m_tstrb;
   logic         m_tready = 1'b1;
   logic         s_tvalid = 1'b0;
   logic [31:0]  s_tdata = '0;
   logic         s_tlast = 1'b0;
   logic         s_tready;

   beat_t exp_q[$];
   beat_t resp_q[$];
   int    n_vec = 0;
   int    n_err = 0;
   int    done_cnt = 0;
   int    sent_cnt = 0;
   bit    bp_en = 1'b0;
   bit    gap_en = 1'b0;
   bit    prev_stall = 1'b0;
   logic [31:0] prev_data = '0;
   logic  prev_last = 1'b0;
   logic  s_hs;

   bitcoin_job_dispatcher dut (
      .axis_aclk       (clk),
      .axis_aresetn    (rst_n),
      .start           (start),
      .stop            (stop),
      .header          (header),
      .nonce_start     (nonce_start),
      .nonce_count     (nonce_count),
      .target          (target),
      .busy            (busy),
      .done            (done),
      .found           (found),
      .proto_err       (proto_err),
      .found_nonce     (found_nonce),
      .found_hash      (found_hash),
      .tries           (tries),
      .m00_axis_tvalid (m_tvalid),
      .m00_axis_tdata  (m_tdata),
      .m00_axis_tstrb  (m_tstrb),
      .m00_axis_tlast  (m_tlast),
      .m00_axis_tready (m_tready),
      .s00_axis_tvalid (s_tvalid),
      .s00_axis_tdata  (s_tdata),
      .s00_axis_tstrb  (4'hF),
      .s00_axis_tlast  (s_tlast),
      .s00_axis_tready (s_tready)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Master-side ready: always ready, or a 50% random pattern.
   always @(posedge clk) begin
      #1;
      m_tready = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
   end

   // Hash responder: presents queued beats, optionally with idle gaps.
   always @(posedge clk) begin
      s_hs = s_tvalid && s_tready;
      #1;
      if (s_hs) begin
         resp_q.delete(0);
         s_tvalid = 1'b0;
      end
      if (!s_tvalid && resp_q.size() > 0 && !(gap_en && $urandom_range(0, 1) == 0)) begin
         s_tvalid = 1'b1;
         s_tdata  = resp_q[0].data;
         s_tlast  = resp_q[0].last;
      end
   end

   // Master-side monitor and scoreboard.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", m_tvalid, 1'b1);
            check("hold_data", m_tdata, prev_data);
            check("hold_last", m_tlast, prev_last);
         end
         if (m_tvalid && m_tready) begin
            sent_cnt++;
            check("word_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
               check("tx_data", m_tdata, exp_q[0].data);
               check("tx_last", m_tlast, exp_q[0].last);
               check("tx_strb", m_tstrb, 4'hF);
               exp_q.delete(0);
            end
         end
         prev_stall = m_tvalid && !m_tready;
         prev_data  = m_tdata;
         prev_last  = m_tlast;
         if (done) done_cnt++;
      end
   end

   task automatic push_job(input logic [31:0] base, input logic [31:0] nonce);
      for (int j = 0; j < 19; j++) exp_q.push_back('{data: base + j, last: 1'b0});
      exp_q.push_back('{data: nonce, last: 1'b1});
   endtask

   task automatic push_result(input logic [31:0] w7, input int n_beats);
      for (int k = 0; k < n_beats; k++) begin
         resp_q.push_back('{data: (k == 7) ? w7 : 32'hA0 + k, last: (k == n_beats - 1)});
      end
   endtask

   task automatic start_job(input logic [31:0] base, input logic [31:0] ns,
                            input logic [31:0] nc, input logic [255:0] tgt);
      @(posedge clk);
      #1;
      for (int j = 0; j < 19; j++) header[j*32 +: 32] = base + j;
      nonce_start = ns;
      nonce_count = nc;
      target      = tgt;
      start       = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check("done_seen", seen, 1'b1);
   endtask

   task automatic expect_end(input string tag, input int done_base, input logic e_found,
                             input logic e_perr, input logic [31:0] e_nonce,
                             input logic [31:0] e_tries);
      wait_done(3000);
      repeat (3) @(negedge clk);
      check({tag, "_found"}, found, e_found);
      check({tag, "_proto_err"}, proto_err, e_perr);
      check({tag, "_found_nonce"}, found_nonce, e_nonce);
      check({tag, "_tries"}, tries, e_tries);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done_pulses"}, done_cnt - done_base, 1);
      check({tag, "_tx_left"}, exp_q.size(), 0);
      check({tag, "_rx_left"}, resp_q.size(), 0);
   endtask

   initial begin
      logic [255:0] exp_hash;
      logic [255:0] all_ones;
      int           base_done;
      int           base_sent;
      bit           reached;

      all_ones = '1;
      for (int k = 0; k < 8; k++) exp_hash[k*32 +: 32] = 32'hA0 + k;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_found", found, 1'b0);
      check("rst_tvalid", m_tvalid, 1'b0);
      check("rst_tready", s_tready, 1'b0);
      check("rst_tries", tries, 0);
      check("rst_found_hash", found_hash, 256'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single hit
      base_done = done_cnt;
      push_job(32'h1000, 32'h12345678);
      push_result(32'hA7, 8);
      start_job(32'h1000, 32'h12345678, 1, all_ones);
      expect_end("single", base_done, 1'b1, 1'b0, 32'h12345678, 1);
      check("single_hash", found_hash, exp_hash);
      check("single_hash_w7", found_hash[255:224], 32'hA7);

      // Miss, miss, hit
      base_done = done_cnt;
      for (int n = 5; n <= 7; n++) push_job(32'h1000, n);
      push_result(32'h1, 8);
      push_result(32'h1, 8);
      push_result(32'h0, 8);
      start_job(32'h1000, 5, 10, {32'h0, {224{1'b1}}});
      expect_end("miss_hit", base_done, 1'b1, 1'b0, 32'd7, 3);

      // Exhaustion across the nonce wrap
      base_done = done_cnt;
      push_job(32'h1000, 32'hFFFFFFFE);
      push_job(32'h1000, 32'hFFFFFFFF);
      push_job(32'h1000, 32'h00000000);
      repeat (3) push_result(32'h1, 8);
      start_job(32'h1000, 32'hFFFFFFFE, 3, 256'h0);
      expect_end("wrap", base_done, 1'b0, 1'b0, 32'h0, 3);

      // Backpressure on both streams, same outcome as single hit
      bp_en  = 1'b1;
      gap_en = 1'b1;
      base_done = done_cnt;
      push_job(32'h1000, 32'h12345678);
      push_result(32'hA7, 8);
      start_job(32'h1000, 32'h12345678, 1, all_ones);
      expect_end("bp", base_done, 1'b1, 1'b0, 32'h12345678, 1);
      check("bp_hash", found_hash, exp_hash);
      bp_en  = 1'b0;
      gap_en = 1'b0;

      // Framing error: tlast on result word 4
      base_done = done_cnt;
      push_job(32'h1000, 32'h42);
      push_result(32'h0, 5);
      start_job(32'h1000, 32'h42, 1, all_ones);
      expect_end("frame", base_done, 1'b0, 1'b1, 32'h0, 0);

      // Zero nonce count: immediate done, no traffic
      base_done = done_cnt;
      base_sent = sent_cnt;
      start_job(32'h1000, 32'h99, 0, all_ones);
      wait_done(2);
      repeat (3) @(negedge clk);
      check("zero_traffic", sent_cnt - base_sent, 0);
      check("zero_found", found, 1'b0);
      check("zero_proto_err", proto_err, 1'b0);
      check("zero_done_pulses", done_cnt - base_done, 1);
      check("zero_busy", busy, 1'b0);

      // Stop during the first of ten jobs
      base_done = done_cnt;
      push_job(32'h1000, 32'h300);
      push_result(32'h1, 8);
      stop = 1'b1;
      start_job(32'h1000, 32'h300, 10, 256'h0);
      expect_end("stop", base_done, 1'b0, 1'b0, 32'h300, 1);
      stop = 1'b0;

      // Reset after 7 accepted words, then restart from header word 0
      base_done = done_cnt;
      base_sent = sent_cnt;
      push_job(32'h2000, 32'h55);
      start_job(32'h2000, 32'h55, 1, all_ones);
      reached = 1'b0;
      for (int i = 0; i < 200 && !reached; i++) begin
         @(posedge clk);
         if (sent_cnt - base_sent == 7) reached = 1'b1;
      end
      check("rst_mid_reached", reached, 1'b1);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst_mid_tvalid", m_tvalid, 1'b0);
      check("rst_mid_busy", busy, 1'b0);
      #1;
      rst_n = 1'b1;
      exp_q.delete();
      repeat (3) @(negedge clk);
      check("rst_mid_no_done", done_cnt - base_done, 0);
      base_done = done_cnt;
      push_job(32'h2000, 32'h55);
      push_result(32'hA7, 8);
      start_job(32'h2000, 32'h55, 1, all_ones);
      expect_end("restart", base_done, 1'b1, 1'b0, 32'h55, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
